// File: rtl/ffdiv_issue_ctrl.sv
// ffdiv_issue_ctrl
// Issues one operand pair at a time to the floating-point divider, collects
// the registered result and flags (or a timeout abort record), tags each with
// its measured latency and queues it in a small FIFO for a valid/ready consumer.
module ffdiv_issue_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_op1,
  input  logic [31:0] in_op2,
  output logic        div_en,
  output logic [31:0] div_operand1,
  output logic [31:0] div_operand2,
  input  logic        div_ready,
  input  logic [31:0] div_result,
  input  logic [4:0]  div_flag,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_flag,
  output logic [7:0]  out_cycles,
  output logic        out_tmo,
  output logic        busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW = 46;
  localparam logic [7:0] TMO_CYCLES = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, RUN, CAPT} state_t;

  state_t          state;
  logic [7:0]      cyc_cnt;
  logic [7:0]      cyc_next;
  logic [7:0]      lat_cnt;
  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            accept;
  logic            push;
  logic            pop;
  logic [EW-1:0]   push_data;
  logic [EW-1:0]   head;

  assign in_ready = (state == IDLE) && (count < (AW+1)'(FIFO_DEPTH));
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);
  assign out_valid = (count != '0);
  assign pop      = out_valid && out_ready;

  assign head       = mem[rd_ptr];
  assign out_tmo    = head[45];
  assign out_cycles = head[44:37];
  assign out_flag   = head[36:32];
  assign out_result = head[31:0];

  // Cycle number of the current RUN cycle, saturating so it never wraps.
  always_comb begin
    cyc_next = (cyc_cnt == 8'hFF) ? 8'hFF : cyc_cnt + 8'd1;
  end

  // A FIFO entry is produced either by a timeout abort in RUN or by CAPT.
  always_comb begin
    push      = 1'b0;
    push_data = '0;
    case (state)
      RUN: begin
        if (!div_ready && (cyc_next == TMO_CYCLES)) begin
          push      = 1'b1;
          push_data = {1'b1, TMO_CYCLES, 5'b10000, 32'h7FC00000};
        end
      end
      CAPT: begin
        push      = 1'b1;
        push_data = {1'b0, lat_cnt, div_flag, div_result};
      end
      default: ;
    endcase
  end

  // Issue FSM: accept a pair, hold the divider enabled until ready or timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      div_en       <= 1'b0;
      div_operand1 <= '0;
      div_operand2 <= '0;
      cyc_cnt      <= '0;
      lat_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            div_operand1 <= in_op1;
            div_operand2 <= in_op2;
            div_en       <= 1'b1;
            cyc_cnt      <= '0;
            state        <= RUN;
          end
        end
        RUN: begin
          cyc_cnt <= cyc_next;
          if (div_ready) begin
            lat_cnt <= cyc_next;
            div_en  <= 1'b0;
            state   <= CAPT;
          end else if (cyc_next == TMO_CYCLES) begin
            div_en <= 1'b0;
            state  <= IDLE;
          end
        end
        CAPT: begin
          state <= IDLE;
        end
        default: begin
          div_en <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // Result FIFO storage and pointers; push and pop may happen together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ffdiv_issue_ctrl.sv
// Testbench for ffdiv_issue_ctrl: a behavioural divider stub with per-job
// latency plus a queue of expected FIFO entries derived from the job list.
module tb_ffdiv_issue_ctrl;

  localparam int DEPTH = 4;
  localparam int TMO   = 64;

  typedef struct packed {
    logic        tmo;
    logic [7:0]  cycles;
    logic [4:0]  flag;
    logic [31:0] result;
  } entry_t;

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    int          lat;
    logic [31:0] res;
    logic [4:0]  flag;
  } job_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_op1;
  logic [31:0] in_op2;
  logic        div_en;
  logic [31:0] div_operand1;
  logic [31:0] div_operand2;
  logic        div_ready;
  logic [31:0] div_result;
  logic [4:0]  div_flag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_flag;
  logic [7:0]  out_cycles;
  logic        out_tmo;
  logic        busy;

  int checks = 0;
  int passed = 0;

  job_t   job_q[$];
  entry_t exp_q[$];
  int     gap_q[$];
  bit     manual = 1'b0;
  int     run_cnt = 0;
  int     low_cnt = 0;
  job_t   cur;

  ffdiv_issue_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op1(in_op1), .in_op2(in_op2),
    .div_en(div_en), .div_operand1(div_operand1), .div_operand2(div_operand2),
    .div_ready(div_ready), .div_result(div_result), .div_flag(div_flag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_flag(out_flag), .out_cycles(out_cycles), .out_tmo(out_tmo), .busy(busy)
  );

  always #5 clk = ~clk;

  // Divider stub: raises div_ready after the job's latency, then shows the
  // result only in the following cycle; other cycles carry random junk.
  always @(negedge clk) begin
    if (!manual) begin
      if (div_ready) begin
        div_ready  = 1'b0;
        div_result = cur.res;
        div_flag   = cur.flag;
      end else begin
        div_result = $urandom;
        div_flag   = 5'($urandom_range(31));
      end
      if (div_en) begin
        if (run_cnt == 0) begin
          gap_q.push_back(low_cnt);
          low_cnt = 0;
          if (job_q.size() > 0) cur = job_q.pop_front();
          checks++;
          if (div_operand1 !== cur.op1 || div_operand2 !== cur.op2)
            $display("[TB] FAIL operands got %h/%h want %h/%h", div_operand1, div_operand2, cur.op1, cur.op2);
          else passed++;
        end
        run_cnt++;
        if (cur.lat != 0 && run_cnt == cur.lat) div_ready = 1'b1;
      end else begin
        run_cnt = 0;
        low_cnt++;
      end
    end
  end

  function automatic entry_t expect_entry(input int lat, input logic [31:0] res, input logic [4:0] flag);
    if (lat == 0 || lat > TMO) return {1'b1, 8'(TMO), 5'b10000, 32'h7FC00000};
    return {1'b0, 8'(lat), flag, res};
  endfunction

  task automatic drive_job(input logic [31:0] op1, input logic [31:0] op2, input int lat,
                           input logic [31:0] res, input logic [4:0] flag);
    job_t j;
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 2000) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++;
      $display("[TB] FAIL accept_wait in_ready got 0 want 1");
      return;
    end
    j.op1 = op1; j.op2 = op2; j.lat = lat; j.res = res; j.flag = flag;
    job_q.push_back(j);
    exp_q.push_back(expect_entry(lat, res, flag));
    in_valid = 1'b1; in_op1 = op1; in_op2 = op2;
    @(posedge clk); #1;
    in_valid = 1'b0; in_op1 = $urandom; in_op2 = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 2000) begin @(negedge clk); n++; end
    if (busy) begin checks++; $display("[TB] FAIL idle_wait busy got 1 want 0"); end
  endtask

  task automatic pop_entry(output entry_t e, output bit ok);
    int n = 0;
    ok = 1'b0; e = '0;
    @(negedge clk);
    while (!out_valid && n < 2000) begin @(negedge clk); n++; end
    if (out_valid) begin
      ok = 1'b1;
      e = {out_tmo, out_cycles, out_flag, out_result};
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; div_ready = 1'b0;
    in_op1 = '0; in_op2 = '0; div_result = '0; div_flag = '0;
    job_q.delete(); exp_q.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (div_en !== 1'b0) $display("[TB] FAIL reset_div_en got %b want 0", div_en); else passed++;
    checks++; if ({div_operand1, div_operand2} !== 64'h0) $display("[TB] FAIL reset_operands got %h want 0", {div_operand1, div_operand2}); else passed++;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); else passed++;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); else passed++;
    checks++; if ({out_tmo, out_cycles, out_flag, out_result} !== 46'h0) $display("[TB] FAIL reset_out_fields got %h want 0", {out_tmo, out_cycles, out_flag, out_result}); else passed++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", busy); else passed++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_divide();
    entry_t got, exp;
    bit ok;
    int n = 0;
    drive_job(32'h40C00000, 32'h40000000, 10, 32'h40400000, 5'b00000);
    checks++; if (div_en !== 1'b1 || busy !== 1'b1) $display("[TB] FAIL single_enable got en=%b busy=%b want 1/1", div_en, busy); else passed++;
    do begin @(negedge clk); n++; end while (!out_valid && n < 200);
    checks++; if (n !== 12) $display("[TB] FAIL single_latency got %0d want 12", n); else passed++;
    pop_entry(got, ok); exp = exp_q.pop_front();
    checks++; if (!ok || got !== exp) $display("[TB] FAIL single_entry got %h want %h", got, exp); else passed++;
  endtask

  task automatic test_div_by_zero();
    entry_t got, exp;
    bit ok;
    drive_job(32'h3F800000, 32'h00000000, $urandom_range(1, 20), 32'h7F800000, 5'b00100);
    pop_entry(got, ok); exp = exp_q.pop_front();
    checks++; if (!ok || got !== exp) $display("[TB] FAIL div_zero_entry got %h want %h", got, exp); else passed++;
  endtask

  task automatic test_timeout();
    entry_t got, exp;
    bit ok;
    int n = 0;
    drive_job($urandom, $urandom, 0, 32'h0, 5'b0);
    @(negedge clk);
    while (div_en && n < 300) begin n++; @(negedge clk); end
    checks++; if (n !== TMO) $display("[TB] FAIL timeout_en_cycles got %0d want %0d", n, TMO); else passed++;
    checks++; if (out_valid !== 1'b1 || busy !== 1'b0) $display("[TB] FAIL timeout_visible got valid=%b busy=%b want 1/0", out_valid, busy); else passed++;
    pop_entry(got, ok); exp = exp_q.pop_front();
    checks++; if (!ok || got !== exp) $display("[TB] FAIL timeout_entry got %h want %h", got, exp); else passed++;
    drive_job($urandom, $urandom, TMO, $urandom, 5'($urandom_range(31)));
    pop_entry(got, ok); exp = exp_q.pop_front();
    checks++; if (!ok || got !== exp) $display("[TB] FAIL ready_at_timeout got %h want %h", got, exp); else passed++;
    drive_job($urandom, $urandom, TMO + 1, $urandom, 5'($urandom_range(31)));
    pop_entry(got, ok); exp = exp_q.pop_front();
    checks++; if (!ok || got !== exp) $display("[TB] FAIL ready_past_timeout got %h want %h", got, exp); else passed++;
  endtask

  task automatic test_backpressure();
    entry_t got, exp;
    job_t j;
    bit ok;
    bit stuck_ok = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      drive_job($urandom, $urandom, $urandom_range(1, 6), $urandom, 5'($urandom_range(31)));
    wait_idle();
    j.op1 = $urandom; j.op2 = $urandom; j.lat = $urandom_range(1, 6); j.res = $urandom; j.flag = 5'($urandom_range(31));
    job_q.push_back(j);
    exp_q.push_back(expect_entry(j.lat, j.res, j.flag));
    in_valid = 1'b1; in_op1 = j.op1; in_op2 = j.op2;
    repeat (10) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || div_en !== 1'b0) stuck_ok = 1'b0;
    end
    checks++; if (!stuck_ok) $display("[TB] FAIL full_blocks got in_ready=%b div_en=%b want 0/0", in_ready, div_en); else passed++;
    pop_entry(got, ok); exp = exp_q.pop_front();
    checks++; if (!ok || got !== exp) $display("[TB] FAIL bp_first got %h want %h", got, exp); else passed++;
    checks++; if (in_ready !== 1'b1 || div_en !== 1'b0) $display("[TB] FAIL bp_after_pop got in_ready=%b div_en=%b want 1/0", in_ready, div_en); else passed++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (div_en !== 1'b1) $display("[TB] FAIL bp_fifth_accept got %b want 1", div_en); else passed++;
    for (int i = 0; i < DEPTH; i++) begin
      pop_entry(got, ok); exp = exp_q.pop_front();
      checks++; if (!ok || got !== exp) $display("[TB] FAIL bp_order[%0d] got %h want %h", i, got, exp); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    entry_t got, exp;
    bit ok;
    gap_q.delete();
    for (int i = 0; i < 3; i++)
      drive_job($urandom, $urandom, $urandom_range(1, 8), $urandom, 5'($urandom_range(31)));
    wait_idle();
    checks++; if (gap_q.size() !== 3) $display("[TB] FAIL b2b_jobs got %0d want 3", gap_q.size());
    else if (gap_q[1] !== 2 || gap_q[2] !== 2) begin
      $display("[TB] FAIL b2b_gap got %0d,%0d want 2,2", gap_q[1], gap_q[2]);
    end else passed++;
    for (int i = 0; i < 3; i++) begin
      pop_entry(got, ok); exp = exp_q.pop_front();
      checks++; if (!ok || got !== exp) $display("[TB] FAIL b2b_entry[%0d] got %h want %h", i, got, exp); else passed++;
    end
  endtask

  task automatic test_push_pop_wrap();
    entry_t got, exp;
    bit ok;
    int n;
    for (int r = 0; r < 5; r++) begin
      for (int j = 0; j < 3; j++)
        drive_job($urandom, $urandom, $urandom_range(1, 5), $urandom, 5'($urandom_range(31)));
      drive_job($urandom, $urandom, 3, $urandom, 5'($urandom_range(31)));
      n = 0;
      @(negedge clk);
      while (!div_ready && n < 200) begin @(negedge clk); n++; end
      @(negedge clk);
      got = {out_tmo, out_cycles, out_flag, out_result};
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      exp = exp_q.pop_front();
      checks++; if (got !== exp) $display("[TB] FAIL pushpop_head[%0d] got %h want %h", r, got, exp); else passed++;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b1) $display("[TB] FAIL pushpop_count[%0d] got in_ready=%b valid=%b want 1/1", r, in_ready, out_valid); else passed++;
      for (int k = 0; k < 3; k++) begin
        pop_entry(got, ok); exp = exp_q.pop_front();
        checks++; if (!ok || got !== exp) $display("[TB] FAIL pushpop_drain[%0d] got %h want %h", r, got, exp); else passed++;
      end
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL pushpop_empty got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_reset_mid_run();
    entry_t got, exp;
    bit ok;
    int n = 0;
    drive_job($urandom, $urandom, 3, $urandom, 5'($urandom_range(31)));
    wait_idle();
    drive_job($urandom, $urandom, 0, 32'h0, 5'b0);
    while (n < 5) begin @(negedge clk); if (div_en) n++; end
    rst_n = 1'b0;
    #1;
    checks++; if (div_en !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL midrun_reset got en=%b valid=%b busy=%b want 0/0/0", div_en, out_valid, busy); else passed++;
    job_q.delete(); exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    manual = 1'b1;
    @(negedge clk);
    div_ready = 1'b1; div_result = 32'h12345678; div_flag = 5'b01010;
    @(negedge clk);
    div_ready = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL late_ready got valid=%b busy=%b want 0/0", out_valid, busy); else passed++;
    manual = 1'b0;
    drive_job($urandom, $urandom, 7, $urandom, 5'($urandom_range(31)));
    pop_entry(got, ok); exp = exp_q.pop_front();
    checks++; if (!ok || got !== exp) $display("[TB] FAIL after_reset_job got %h want %h", got, exp); else passed++;
  endtask

  // Hard stop in case a bounded wait is itself broken.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog simulation did not finish, passed %0d of %0d", passed, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenario sequence.
  initial begin
    test_reset();
    test_single_divide();
    test_div_by_zero();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_push_pop_wrap();
    test_reset_mid_run();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ffdiv_issue_ctrl.md
# ffdiv_issue_ctrl

Issue/collect controller placed directly upstream of the 32-bit floating-point divider top. It accepts operand pairs over a valid/ready stream and drives the divider's enable and operand inputs. It captures the registered result and 5-bit flag vector, then buffers completed results in a small FIFO toward a valid/ready consumer. It also measures per-operation latency and aborts operations that never complete.

## Interface
- `FIFO_DEPTH`, default 4: result FIFO entries; power of 2, ≥2.
- `TIMEOUT`, default 64: max cycles with `div_en` high before abort; range 2..255.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  controller can accept a pair.
- `in_op1`  in  32  IEEE-754 single dividend.
- `in_op2`  in  32  IEEE-754 single divisor.
- `div_en`  out  1  divider enable, registered.
- `div_operand1`  out  32  to divider, registered.
- `div_operand2`  out  32  to divider, registered.
- `div_ready`  in  1  divider completion.
- `div_result`  in  32  divider registered result.
- `div_flag`  in  5  {nanf, ovf, inf, uf, zf}.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer pops head.
- `out_result`  out  32  head result.
- `out_flag`  out  5  head flags.
- `out_cycles`  out  8  head latency: `div_en`-high cycles until `div_ready` was sampled, saturating at 255.
- `out_tmo`  out  1  head entry was a timeout abort.
- `busy`  out  1  state ≠ IDLE.

## Operation
- **FIFO entry:** {tmo, cycles[7:0], flag[4:0], result[31:0]}. Storage, pointers and count reset to 0. `out_*` always show the head.
- **IDLE**
  - `in_ready = (count < FIFO_DEPTH)`. Only one job is ever in flight, so the push slot is guaranteed at accept time.
  - On `in_valid && in_ready`: register operands to `div_operand1/2`, set `div_en=1`, clear cycle counter, go to RUN.
  - `div_ready` is ignored in IDLE.
- **RUN**
  - `div_en=1`, operands held stable. Cycle counter increments each cycle, starting at 1 in the first RUN cycle.
  - `div_ready` sampled 1: latch counter value, `div_en<=0`, go to CAPT.
  - Else, counter == `TIMEOUT`: `div_en<=0`, push {1, TIMEOUT, 5'b10000, 32'h7FC00000}, go to IDLE.
  - `div_ready` and the timeout condition in the same cycle: `div_ready` wins.
- **CAPT**
  - `div_en=0`. Sample `div_result` and `div_flag` this cycle; they are valid in the cycle after `div_ready` was high.
  - Push {0, latched count, div_flag, div_result}, go to IDLE.
  - `div_ready` is ignored.
- **Enable gap:** `div_en` is low for ≥1 cycle between consecutive operations. IDLE always lasts ≥1 cycle, and CAPT adds one more.
- **FIFO**
  - Pop when `out_valid && out_ready`.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Pop when empty: ignored. Pointers wrap modulo `FIFO_DEPTH`.
- **Flags:** passed through unmodified. No arithmetic is performed on the result.

## Timing
- **Reset values:** state IDLE, `div_en=0`, `div_operand1/2=0`, `in_ready=1`, `out_valid=0`, `out_result=0`, `out_flag=0`, `out_cycles=0`, `out_tmo=0`, `busy=0`.
- **Accept to enable:** handshake at edge k → `div_en` high from edge k to k+1.
- **Ready to output:** `div_ready` sampled at edge r → CAPT in cycle r..r+1 → push at edge r+1 → `out_valid` high after edge r+1. Latency from `div_ready` to `out_valid` is 2 edges.
- **Back-to-back:** next accept is earliest at edge r+2. `div_en` is low for ≥2 cycles between jobs.
- **Abort:** timeout entry is visible 1 edge after the `TIMEOUT`-th RUN cycle.
- **Reset mid-operation:**
  - `rst_n` low asynchronously forces `div_en=0` and empties the FIFO.
  - The in-flight job is discarded; no entry is produced.
  - A late `div_ready` after reset is ignored (state is IDLE).
- **Output stability:** `out_*` are stable while `out_valid && !out_ready`.

## Test plan
- **Single divide:** `in_op1`=0x40C00000, `in_op2`=0x40000000; model asserts `div_ready` 10 cycles after `div_en` rises and presents 0x40400000 the next cycle → one entry: result 0x40400000, flag 5'b00000, cycles 10, tmo 0. `out_valid` rises 2 edges after `div_ready`.
- **Divide by zero:** 0x3F800000 / 0x00000000; model returns 0x7F800000 with flag 5'b00100 → entry passes both through unchanged, tmo 0.
- **Backpressure:**
  - Hold `out_ready=0` and issue 5 jobs → `in_ready` low after 4 completions; the 5th is not accepted and `div_en` stays low.
  - Pop one → 5th job accepted next cycle.
  - Results emerge in issue order.
- **Timeout:** model never asserts `div_ready` → after 64 `div_en`-high cycles `div_en` falls, entry is {tmo 1, cycles 64, flag 5'b10000, result 0x7FC00000}, controller returns to IDLE and accepts again.
- **Push and pop together:** count=3 and `out_ready=1` on the cycle a CAPT push occurs → count stays 3, head advances, no lost or duplicated entry across pointer wrap (run 20 jobs).
- **Reset mid-run:** assert `rst_n` low at RUN cycle 5 → `div_en` low immediately, `out_valid=0`. After release, a late `div_ready` pulse produces no entry, and the next job completes normally.
